jpeg_frame_sequencer: RTL and testbench

Output-side scheduler for the compressor's single 8-bit byte stream. It sequences each frame as a header from a header EBR/ROM, then the byte-stuffed entropy-coded body, then the EOI marker (0xFF 0xD9). Entropy bytes that arrive while the header is still being emitted are held in an internal FIFO. It sits between the bytestuffer output and the top-level hsync/data_out pins.

---
 rtl/jpeg_frame_sequencer_if.sv | 28 ++
 rtl/jpeg_frame_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_jpeg_frame_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_frame_sequencer_if.sv
// Byte-stream bundle between the frame sequencer, its header ROM and the output pins.
// The slave side is the sequencer; the master side is the surrounding datapath.
interface jpeg_frame_sequencer_if #(
    parameter int HDR_ADDR_WIDTH = 10
);
    logic                      frame_start;
    logic                      frame_end;
    logic                      ent_valid;
    logic [7:0]                ent_data;
    logic [HDR_ADDR_WIDTH-1:0] hdr_rom_addr;
    logic [7:0]                hdr_rom_data;
    logic                      out_valid;
    logic [7:0]                out_data;
    logic                      busy;
    logic                      frame_done;
    logic                      overflow;
    logic                      protocol_err;

    modport slave (
        input  frame_start, frame_end, ent_valid, ent_data, hdr_rom_data,
        output hdr_rom_addr, out_valid, out_data, busy, frame_done, overflow, protocol_err
    );

    modport master (
        output frame_start, frame_end, ent_valid, ent_data, hdr_rom_data,
        input  hdr_rom_addr, out_valid, out_data, busy, frame_done, overflow, protocol_err
    );
endinterface

// File: rtl/jpeg_frame_sequencer.sv
// Frame output scheduler: header ROM bytes, then buffered/bypassed entropy bytes, then EOI.
// state    | meaning
// IDLE     | waiting for frame_start; ROM address parked at 0
// HEADER   | streaming header ROM bytes, entropy bytes queued in FIFO
// BODY     | draining FIFO, else bypassing live entropy bytes
// EOI_FF   | 0xFF of the EOI marker is on the pins
// EOI_D9   | 0xD9 of the EOI marker is on the pins, frame_done high
module jpeg_frame_sequencer #(
    parameter int HEADER_LENGTH   = 589,
    parameter int HDR_ADDR_WIDTH  = 10,
    parameter int FIFO_DEPTH_LOG2 = 6
) (
    input  logic                  i_clock,
    input  logic                  i_nreset,
    jpeg_frame_sequencer_if.slave io_bus
);
    localparam int AW = HDR_ADDR_WIDTH;
    localparam int FW = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << FW;
    localparam logic [AW-1:0] LP_HDR_LAST = AW'(HEADER_LENGTH - 1);
    localparam logic [AW-1:0] LP_HDR_ONE  = AW'(1);
    localparam logic [FW:0]   LP_PTR_ONE  = (FW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_BODY,
        S_EOI_FF,
        S_EOI_D9
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_hdr_addr;
    logic [AW-1:0]   w_hdr_addr_nxt;
    logic [AW-1:0]   r_hdr_left;
    logic [AW-1:0]   w_hdr_left_nxt;
    logic            r_end_latch;
    logic            w_end_latch_nxt;
    logic            r_out_valid;
    logic            w_out_valid_nxt;
    logic [7:0]      r_out_data;
    logic [7:0]      w_out_data_nxt;
    logic            r_busy;
    logic            r_frame_done;
    logic            w_frame_done_nxt;
    logic            r_overflow;
    logic            r_protocol_err;
    logic            w_drop;
    logic            w_perr;

    logic [7:0]      r_mem [DEPTH];
    logic [FW:0]     r_wr_ptr;
    logic [FW:0]     r_rd_ptr;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic [7:0]      w_fifo_head;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[FW] != r_rd_ptr[FW]) &&
                         (r_wr_ptr[FW-1:0] == r_rd_ptr[FW-1:0]);
    assign w_fifo_head = r_mem[r_rd_ptr[FW-1:0]];

    always_comb begin
        w_state_nxt      = r_state;
        w_hdr_addr_nxt   = r_hdr_addr;
        w_hdr_left_nxt   = r_hdr_left;
        w_end_latch_nxt  = r_end_latch;
        w_out_valid_nxt  = 1'b0;
        w_out_data_nxt   = 8'h00;
        w_frame_done_nxt = 1'b0;
        w_push           = 1'b0;
        w_pop            = 1'b0;
        w_drop           = 1'b0;
        w_perr           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (io_bus.ent_valid) begin
                    w_perr = 1'b1;
                end
                if (io_bus.frame_start) begin
                    // Address 0 is already on the ROM this cycle, so the next one is 1.
                    w_state_nxt     = S_HEADER;
                    w_hdr_left_nxt  = LP_HDR_LAST;
                    w_hdr_addr_nxt  = (LP_HDR_LAST != '0) ? LP_HDR_ONE : '0;
                    w_end_latch_nxt = 1'b0;
                end
            end

            S_HEADER: begin
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = io_bus.hdr_rom_data;
                if (r_hdr_left == '0) begin
                    w_state_nxt    = S_BODY;
                    w_hdr_addr_nxt = '0;
                end else begin
                    w_hdr_left_nxt = r_hdr_left - LP_HDR_ONE;
                    if (r_hdr_addr != LP_HDR_LAST) begin
                        w_hdr_addr_nxt = r_hdr_addr + LP_HDR_ONE;
                    end
                end
                if (io_bus.ent_valid) begin
                    w_push = !w_full;
                    w_drop = w_full;
                end
                if (io_bus.frame_end) begin
                    w_end_latch_nxt = 1'b1;
                end
                w_perr = io_bus.frame_start;
            end

            S_BODY: begin
                if (!w_empty) begin
                    // Popping frees a slot, so a push is always accepted here.
                    w_pop           = 1'b1;
                    w_push          = io_bus.ent_valid;
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = w_fifo_head;
                end else if (io_bus.ent_valid) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = io_bus.ent_data;
                end else if (r_end_latch) begin
                    w_state_nxt     = S_EOI_FF;
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = 8'hFF;
                end
                if (io_bus.frame_end) begin
                    w_end_latch_nxt = 1'b1;
                end
                w_perr = io_bus.frame_start;
            end

            S_EOI_FF: begin
                w_state_nxt      = S_EOI_D9;
                w_out_valid_nxt  = 1'b1;
                w_out_data_nxt   = 8'hD9;
                w_frame_done_nxt = 1'b1;
                w_drop           = io_bus.ent_valid;
                w_perr           = io_bus.frame_start;
            end

            S_EOI_D9: begin
                w_state_nxt = S_IDLE;
                w_drop      = io_bus.ent_valid;
                w_perr      = io_bus.frame_start;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_nreset) begin
            r_state        <= S_IDLE;
            r_hdr_addr     <= '0;
            r_hdr_left     <= '0;
            r_end_latch    <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= 8'h00;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overflow     <= 1'b0;
            r_protocol_err <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_hdr_addr     <= w_hdr_addr_nxt;
            r_hdr_left     <= w_hdr_left_nxt;
            r_end_latch    <= w_end_latch_nxt;
            r_out_valid    <= w_out_valid_nxt;
            r_out_data     <= w_out_data_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
            r_frame_done   <= w_frame_done_nxt;
            r_overflow     <= r_overflow | w_drop;
            r_protocol_err <= r_protocol_err | w_perr;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_nreset && w_push) begin
            r_mem[r_wr_ptr[FW-1:0]] <= io_bus.ent_data;
        end
    end

    assign io_bus.hdr_rom_addr = r_hdr_addr;
    assign io_bus.out_valid    = r_out_valid;
    assign io_bus.out_data     = r_out_data;
    assign io_bus.busy         = r_busy;
    assign io_bus.frame_done   = r_frame_done;
    assign io_bus.overflow     = r_overflow;
    assign io_bus.protocol_err = r_protocol_err;
endmodule

// File: tb/tb_jpeg_frame_sequencer.sv
// Directed bench: a 4-byte-header instance with a 64-deep FIFO and a 16-byte-header
// instance with a 4-deep FIFO, driven by hand-built cycle sequences.
module tb_jpeg_frame_sequencer;
    logic clk = 1'b0;
    logic nreset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] rom_a [4];
    logic [7:0] rom_b [16];
    logic [7:0] exp_hdr_a [4];

    jpeg_frame_sequencer_if #(.HDR_ADDR_WIDTH(10)) bus_a ();
    jpeg_frame_sequencer_if #(.HDR_ADDR_WIDTH(4))  bus_b ();

    jpeg_frame_sequencer #(
        .HEADER_LENGTH(4), .HDR_ADDR_WIDTH(10), .FIFO_DEPTH_LOG2(6)
    ) dut_a (
        .i_clock(clk), .i_nreset(nreset), .io_bus(bus_a.slave)
    );

    jpeg_frame_sequencer #(
        .HEADER_LENGTH(16), .HDR_ADDR_WIDTH(4), .FIFO_DEPTH_LOG2(2)
    ) dut_b (
        .i_clock(clk), .i_nreset(nreset), .io_bus(bus_b.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus_a.hdr_rom_data <= rom_a[bus_a.hdr_rom_addr[1:0]];
        bus_b.hdr_rom_data <= rom_b[bus_b.hdr_rom_addr];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic out_a(input string tag, input bit exp_v, input logic [7:0] exp_d);
        chk({tag, ".valid"}, 32'(bus_a.out_valid), 32'(exp_v));
        if (exp_v) chk({tag, ".data"}, 32'(bus_a.out_data), 32'(exp_d));
    endtask

    task automatic out_b(input string tag, input bit exp_v, input logic [7:0] exp_d);
        chk({tag, ".valid"}, 32'(bus_b.out_valid), 32'(exp_v));
        if (exp_v) chk({tag, ".data"}, 32'(bus_b.out_data), 32'(exp_d));
    endtask

    task automatic ent_a(input bit v, input logic [7:0] d, input bit fe);
        bus_a.ent_valid = v;
        bus_a.ent_data  = d;
        bus_a.frame_end = fe;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, ".valid"}, 32'(bus_a.out_valid), 32'd0);
        chk({tag, ".data"},  32'(bus_a.out_data),  32'd0);
        chk({tag, ".addr"},  32'(bus_a.hdr_rom_addr), 32'd0);
        chk({tag, ".busy"},  32'(bus_a.busy), 32'd0);
        chk({tag, ".done"},  32'(bus_a.frame_done), 32'd0);
        chk({tag, ".ovf"},   32'(bus_a.overflow), 32'd0);
        chk({tag, ".perr"},  32'(bus_a.protocol_err), 32'd0);
    endtask

    task automatic header_a(input string tag);
        for (int k = 0; k < 4; k++) begin
            cyc();
            out_a(tag, 1'b1, exp_hdr_a[k]);
        end
    endtask

    task automatic eoi_a(input string tag);
        cyc();
        out_a({tag, ".ff"}, 1'b1, 8'hFF);
        chk({tag, ".ff_done"}, 32'(bus_a.frame_done), 32'd0);
        cyc();
        out_a({tag, ".d9"}, 1'b1, 8'hD9);
        chk({tag, ".d9_done"}, 32'(bus_a.frame_done), 32'd1);
        chk({tag, ".d9_busy"}, 32'(bus_a.busy), 32'd1);
        cyc();
        out_a({tag, ".after"}, 1'b0, 8'h00);
        chk({tag, ".idle_busy"}, 32'(bus_a.busy), 32'd0);
        chk({tag, ".idle_done"}, 32'(bus_a.frame_done), 32'd0);
    endtask

    initial begin
        rom_a     = '{8'hFF, 8'hD8, 8'hFF, 8'hDB};
        exp_hdr_a = '{8'hFF, 8'hD8, 8'hFF, 8'hDB};
        for (int i = 0; i < 16; i++) rom_b[i] = 8'h80 + 8'(i);

        nreset = 1'b0;
        bus_a.frame_start = 1'b0;
        ent_a(1'b0, 8'h00, 1'b0);
        bus_b.frame_start = 1'b0;
        bus_b.frame_end   = 1'b0;
        bus_b.ent_valid   = 1'b0;
        bus_b.ent_data    = 8'h00;
        cyc();
        cyc();
        chk_reset_a("reset");
        chk("reset.b_busy", 32'(bus_b.busy), 32'd0);
        chk("reset.b_ovf", 32'(bus_b.overflow), 32'd0);
        nreset = 1'b1;
        cyc();
        cyc();

        // Frame 1: header, two late body bytes with frame_end on the second, EOI.
        bus_a.frame_start = 1'b1;
        cyc();
        bus_a.frame_start = 1'b0;
        chk("t1.addr1", 32'(bus_a.hdr_rom_addr), 32'd1);
        chk("t1.busy", 32'(bus_a.busy), 32'd1);
        out_a("t1.lat", 1'b0, 8'h00);
        header_a("t1.hdr");
        for (int i = 0; i < 14; i++) begin
            cyc();
            out_a("t1.gap", 1'b0, 8'h00);
        end
        chk("t1.addr_body", 32'(bus_a.hdr_rom_addr), 32'd0);
        ent_a(1'b1, 8'h11, 1'b0);
        cyc();
        out_a("t1.b11", 1'b1, 8'h11);
        ent_a(1'b1, 8'h22, 1'b1);
        cyc();
        out_a("t1.b22", 1'b1, 8'h22);
        ent_a(1'b0, 8'h00, 1'b0);
        eoi_a("t1.eoi");
        chk("t1.perr", 32'(bus_a.protocol_err), 32'd0);

        // Frame 2: A0..A5 from the cycle after frame_start, drained contiguously.
        bus_a.frame_start = 1'b1;
        cyc();
        bus_a.frame_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 6) ent_a(1'b1, 8'hA0 + 8'(i), 1'b0);
            else       ent_a(1'b0, 8'h00, 1'b0);
            cyc();
            if (i < 4)       out_a("t2.hdr", 1'b1, exp_hdr_a[i]);
            else if (i < 10) out_a("t2.body", 1'b1, 8'hA0 + 8'(i - 4));
            else             out_a("t2.gap", 1'b0, 8'h00);
        end
        chk("t2.ovf", 32'(bus_a.overflow), 32'd0);
        ent_a(1'b0, 8'h00, 1'b1);
        cyc();
        ent_a(1'b0, 8'h00, 1'b0);
        out_a("t2.end", 1'b0, 8'h00);
        eoi_a("t2.eoi");

        // Small FIFO: six bytes during a 16-byte header, last two dropped.
        bus_b.frame_start = 1'b1;
        cyc();
        bus_b.frame_start = 1'b0;
        for (int i = 0; i < 21; i++) begin
            bus_b.ent_valid = (i < 6);
            bus_b.ent_data  = 8'hC0 + 8'(i);
            cyc();
            if (i < 16)      out_b("t3.hdr", 1'b1, 8'h80 + 8'(i));
            else if (i < 20) out_b("t3.body", 1'b1, 8'hC0 + 8'(i - 16));
            else             out_b("t3.gap", 1'b0, 8'h00);
        end
        bus_b.ent_valid = 1'b0;
        chk("t3.ovf", 32'(bus_b.overflow), 32'd1);
        bus_b.frame_end = 1'b1;
        cyc();
        bus_b.frame_end = 1'b0;
        cyc();
        out_b("t3.ff", 1'b1, 8'hFF);
        cyc();
        out_b("t3.d9", 1'b1, 8'hD9);
        chk("t3.done", 32'(bus_b.frame_done), 32'd1);
        cyc();
        chk("t3.ovf_hold", 32'(bus_b.overflow), 32'd1);
        chk("t3.busy", 32'(bus_b.busy), 32'd0);

        // Second frame_start during HEADER is ignored and flagged.
        bus_a.frame_start = 1'b1;
        cyc();
        bus_a.frame_start = 1'b0;
        cyc();
        out_a("t4.h0", 1'b1, 8'hFF);
        chk("t4.perr_pre", 32'(bus_a.protocol_err), 32'd0);
        bus_a.frame_start = 1'b1;
        cyc();
        bus_a.frame_start = 1'b0;
        out_a("t4.h1", 1'b1, 8'hD8);
        chk("t4.perr", 32'(bus_a.protocol_err), 32'd1);
        cyc();
        out_a("t4.h2", 1'b1, 8'hFF);
        cyc();
        out_a("t4.h3", 1'b1, 8'hDB);
        cyc();
        out_a("t4.gap", 1'b0, 8'h00);
        chk("t4.busy", 32'(bus_a.busy), 32'd1);
        ent_a(1'b1, 8'h5A, 1'b1);
        cyc();
        ent_a(1'b0, 8'h00, 1'b0);
        out_a("t4.b5a", 1'b1, 8'h5A);
        eoi_a("t4.eoi");
        chk("t4.perr_hold", 32'(bus_a.protocol_err), 32'd1);

        nreset = 1'b0;
        cyc();
        chk_reset_a("rst2");
        chk("rst2.b_ovf", 32'(bus_b.overflow), 32'd0);
        nreset = 1'b1;
        cyc();

        // ent_valid while IDLE: dropped, flagged.
        ent_a(1'b1, 8'h33, 1'b0);
        cyc();
        ent_a(1'b0, 8'h00, 1'b0);
        out_a("t4i.out", 1'b0, 8'h00);
        chk("t4i.perr", 32'(bus_a.protocol_err), 32'd1);
        chk("t4i.busy", 32'(bus_a.busy), 32'd0);
        cyc();
        out_a("t4i.out2", 1'b0, 8'h00);

        nreset = 1'b0;
        cyc();
        nreset = 1'b1;
        cyc();
        chk("rst3.perr", 32'(bus_a.protocol_err), 32'd0);

        // Reset in the first BODY cycle with three bytes queued.
        bus_a.frame_start = 1'b1;
        cyc();
        bus_a.frame_start = 1'b0;
        ent_a(1'b1, 8'h91, 1'b0);
        cyc();
        ent_a(1'b1, 8'h92, 1'b0);
        cyc();
        ent_a(1'b1, 8'h93, 1'b0);
        cyc();
        ent_a(1'b0, 8'h00, 1'b0);
        cyc();
        out_a("t5.last_hdr", 1'b1, 8'hDB);
        nreset = 1'b0;
        cyc();
        chk_reset_a("t5.rst");
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            out_a("t5.quiet", 1'b0, 8'h00);
            chk("t5.quiet_busy", 32'(bus_a.busy), 32'd0);
        end

        // Clean frame after reset; frame_end in HEADER with no body goes straight to EOI.
        bus_a.frame_start = 1'b1;
        cyc();
        bus_a.frame_start = 1'b0;
        chk("t5b.addr1", 32'(bus_a.hdr_rom_addr), 32'd1);
        ent_a(1'b0, 8'h00, 1'b1);
        header_a("t5b.hdr");
        ent_a(1'b0, 8'h00, 1'b0);
        eoi_a("t5b.eoi");

        // Final byte and frame_end together with an empty FIFO.
        bus_a.frame_start = 1'b1;
        cyc();
        bus_a.frame_start = 1'b0;
        header_a("t6.hdr");
        cyc();
        out_a("t6.gap", 1'b0, 8'h00);
        ent_a(1'b1, 8'h7E, 1'b1);
        cyc();
        ent_a(1'b0, 8'h00, 1'b0);
        out_a("t6.b7e", 1'b1, 8'h7E);
        eoi_a("t6.eoi");
        chk("t6.ovf", 32'(bus_a.overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
